// File: rtl/fetch_stage.sv
// +-----------------------------------------------------------------------------
// | Module   : fetch_stage
// | Brief    : PC sequencing, instruction-memory addressing and fetch latch.
// |            Optional performance counters under FETCH_PERF_CNT_EN.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
  parameter int            PC_W    = 10,
  parameter int            INSTR_W = 18,
  parameter logic [PC_W-1:0] INT_VEC = 10'h3FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_reset,
  input  logic               pc_inc,
  input  logic               pc_load,
  input  logic [1:0]         pc_load_sel,
  input  logic [PC_W-1:0]    branch_addr,
  input  logic [PC_W-1:0]    ret_addr,
  input  logic               imem_addr_mux,
  input  logic               fetch_latch_stall,
  input  logic               dec_nop,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic               req_v_q, req_v_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic               if_valid_q, if_valid_d;

  // Replay lets a stalled decode keep re-reading the word it is waiting on.
  assign imem_addr = imem_addr_mux ? addr_q : pc_q;

  always_comb begin
    pc_d = pc_q;
    if (reset || pc_reset) begin
      pc_d = '0;
    end else if (pc_load) begin
      case (pc_load_sel)
        2'b01:   pc_d = ret_addr;
        2'b10:   pc_d = INT_VEC;
        default: pc_d = branch_addr;
      endcase
    end else if (pc_inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_comb begin
    addr_d     = reset ? '0 : imem_addr;
    req_v_d    = !(reset || pc_reset);
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    if (reset) begin
      if_instr_d = '0;
      if_pc_d    = '0;
      if_valid_d = 1'b0;
    end else if (!fetch_latch_stall) begin
      if_instr_d = imem_data;
      if_pc_d    = addr_q;
      if_valid_d = req_v_q && !dec_nop;
    end
  end

  always_ff @(posedge clk) begin
    pc_q       <= pc_d;
    addr_q     <= addr_d;
    req_v_q    <= req_v_d;
    if_instr_q <= if_instr_d;
    if_pc_q    <= if_pc_d;
    if_valid_q <= if_valid_d;
  end

  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign if_valid = if_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate rather than wrap so a long run never reads low.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (fetch_latch_stall && (stall_cnt_q != 16'hFFFF))
        stall_cnt_d = stall_cnt_q + 16'd1;
      if (!fetch_latch_stall && dec_nop && req_v_q && (flush_cnt_q != 16'hFFFF))
        flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +-----------------------------------------------------------------------------
// | Module   : tb_fetch_stage
// | Brief    : Directed vector bench for fetch_stage (FETCH_PERF_CNT_EN aware).
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, pc_reset, pc_inc, pc_load;
  logic [1:0]  pc_load_sel;
  logic [9:0]  branch_addr, ret_addr;
  logic        imem_addr_mux, fetch_latch_stall, dec_nop;
  logic [9:0]  imem_addr;
  logic [17:0] imem_data = '0;
  logic [17:0] if_instr;
  logic [9:0]  if_pc;
  logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Synchronous-read memory: each word is its own address with a fixed tag.
  always @(posedge clk) imem_data <= {8'h2A, imem_addr};

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc_reset(pc_reset), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_load_sel(pc_load_sel), .branch_addr(branch_addr),
    .ret_addr(ret_addr), .imem_addr_mux(imem_addr_mux),
    .fetch_latch_stall(fetch_latch_stall), .dec_nop(dec_nop),
    .imem_addr(imem_addr), .imem_data(imem_data), .if_instr(if_instr),
    .if_pc(if_pc), .if_valid(if_valid)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    bit       rst, pcr, inc, ld;
    bit [1:0] sel;
    bit [9:0] br, ret;
    bit       mux, stl, nop;
    bit [9:0] e_addr;   // imem_addr before the edge
    bit [9:0] e_pc;     // if_pc after the edge
    bit       e_v;      // if_valid after the edge
    bit [1:0] ci;       // if_instr: 0 skip, 1 tagged if_pc, 2 zero
  } row_t;

  row_t vec[$];

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    end
  endtask

  function automatic row_t r(input bit rst, pcr, inc, ld, input bit [1:0] sel,
                             input bit [9:0] br, ret, input bit mux, stl, nop,
                             input bit [9:0] ea, ep, input bit ev, input bit [1:0] ci);
    row_t x;
    x.rst = rst; x.pcr = pcr; x.inc = inc; x.ld = ld; x.sel = sel;
    x.br = br; x.ret = ret; x.mux = mux; x.stl = stl; x.nop = nop;
    x.e_addr = ea; x.e_pc = ep; x.e_v = ev; x.ci = ci;
    return x;
  endfunction

  task automatic drive(input row_t x);
    reset = x.rst; pc_reset = x.pcr; pc_inc = x.inc; pc_load = x.ld;
    pc_load_sel = x.sel; branch_addr = x.br; ret_addr = x.ret;
    imem_addr_mux = x.mux; fetch_latch_stall = x.stl; dec_nop = x.nop;
  endtask

  initial begin
    //          rst pcr inc ld sel    br      ret     mux stl nop e_addr  e_pc    v  ci
    vec.push_back(r(0,0,1,0,2'b00,10'h000,10'h000,0,0,0,10'h000,10'h000,0,1)); // 1 first capture invalid
    vec.push_back(r(0,0,1,0,2'b00,10'h000,10'h000,0,0,0,10'h001,10'h000,1,1));
    vec.push_back(r(0,0,1,0,2'b00,10'h000,10'h000,0,0,0,10'h002,10'h001,1,1));
    vec.push_back(r(0,0,1,0,2'b00,10'h000,10'h000,0,0,0,10'h003,10'h002,1,1));
    vec.push_back(r(0,0,1,1,2'b00,10'h3FE,10'h000,0,0,0,10'h004,10'h003,1,1)); // 5 load beats inc
    vec.push_back(r(0,0,1,0,2'b00,10'h000,10'h000,0,0,0,10'h3FE,10'h004,1,1));
    vec.push_back(r(0,0,1,0,2'b00,10'h000,10'h000,0,0,0,10'h3FF,10'h3FE,1,1)); // wrap
    vec.push_back(r(0,0,0,0,2'b00,10'h000,10'h000,0,0,0,10'h000,10'h3FF,1,1));
    vec.push_back(r(0,0,0,1,2'b11,10'h010,10'h000,0,0,0,10'h000,10'h000,1,1)); // sel 11
    vec.push_back(r(0,0,0,1,2'b10,10'h000,10'h000,0,0,1,10'h010,10'h000,0,1)); // 10 vector + nop
    vec.push_back(r(0,0,0,0,2'b00,10'h000,10'h000,0,0,0,10'h3FF,10'h010,1,1));
    vec.push_back(r(0,0,0,1,2'b01,10'h000,10'h055,0,1,0,10'h3FF,10'h010,1,1)); // load under stall
    vec.push_back(r(0,0,0,0,2'b00,10'h000,10'h000,0,1,1,10'h055,10'h010,1,1)); // nop ignored in stall
    vec.push_back(r(0,0,1,0,2'b00,10'h000,10'h000,0,0,0,10'h055,10'h055,1,1));
    vec.push_back(r(0,0,0,1,2'b00,10'h020,10'h000,0,0,0,10'h056,10'h055,1,1)); // 15
    vec.push_back(r(0,0,1,0,2'b00,10'h000,10'h000,0,0,0,10'h020,10'h056,1,1));
    vec.push_back(r(0,0,0,0,2'b00,10'h000,10'h000,1,1,0,10'h020,10'h056,1,1)); // replay + stall
    vec.push_back(r(0,0,0,0,2'b00,10'h000,10'h000,1,1,0,10'h020,10'h056,1,1));
    vec.push_back(r(0,0,0,0,2'b00,10'h000,10'h000,1,0,0,10'h020,10'h020,1,1)); // release
    vec.push_back(r(0,0,1,0,2'b00,10'h000,10'h000,0,0,0,10'h021,10'h020,1,1)); // 20
    vec.push_back(r(0,1,1,1,2'b10,10'h000,10'h000,0,0,0,10'h022,10'h021,1,1)); // pc_reset wins
    vec.push_back(r(0,0,1,0,2'b00,10'h000,10'h000,0,0,0,10'h000,10'h022,0,1));
    vec.push_back(r(0,0,1,0,2'b00,10'h000,10'h000,0,0,0,10'h001,10'h000,1,1));
    vec.push_back(r(1,0,0,0,2'b00,10'h000,10'h000,0,1,0,10'h002,10'h000,0,2)); // reset mid-stall
    vec.push_back(r(0,0,0,0,2'b00,10'h000,10'h000,0,0,0,10'h000,10'h000,0,0)); // 25

    drive(r(1,0,0,0,2'b00,10'h000,10'h000,0,0,0,10'h000,10'h000,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_if_instr", 0, 32'(if_instr), 32'h0);
    chk("reset_if_pc",    0, 32'(if_pc),    32'h0);
    chk("reset_if_valid", 0, 32'(if_valid), 32'h0);
    chk("reset_imem_addr",0, 32'(imem_addr),32'h0);
    imem_addr_mux = 1'b1;
    #1 chk("reset_addr_q", 0, 32'(imem_addr), 32'h0);

    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk);
      drive(vec[i]);
      #1 chk("imem_addr", i + 1, 32'(imem_addr), 32'(vec[i].e_addr));
      @(posedge clk);
      #1;
      chk("if_pc",    i + 1, 32'(if_pc),    32'(vec[i].e_pc));
      chk("if_valid", i + 1, 32'(if_valid), 32'(vec[i].e_v));
      if (vec[i].ci == 2'd1) chk("if_instr", i + 1, 32'(if_instr), 32'({8'h2A, vec[i].e_pc}));
      if (vec[i].ci == 2'd2) chk("if_instr", i + 1, 32'(if_instr), 32'h0);
    end

`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    drive(r(1,0,0,0,2'b00,10'h000,10'h000,0,0,0,10'h000,10'h000,0,0));
    @(negedge clk);
    chk("stall_cnt_rst", 100, 32'(stall_cnt), 32'h0);
    chk("flush_cnt_rst", 100, 32'(flush_cnt), 32'h0);
    reset = 1'b0;
    @(negedge clk);   // req_v becomes 1; no events counted yet
    fetch_latch_stall = 1'b1;
    repeat (3) @(negedge clk);
    fetch_latch_stall = 1'b0;
    dec_nop = 1'b1;
    repeat (2) @(negedge clk);
    dec_nop = 1'b0;
    chk("stall_cnt_3", 101, 32'(stall_cnt), 32'd3);
    chk("flush_cnt_2", 101, 32'(flush_cnt), 32'd2);
    fetch_latch_stall = 1'b1;
    repeat (65540) @(negedge clk);
    fetch_latch_stall = 1'b0;
    chk("stall_cnt_sat", 102, 32'(stall_cnt), 32'hFFFF);
    chk("flush_cnt_hold", 102, 32'(flush_cnt), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have ports, clock and reset first:
  clk  in  1  system clock; all state updates on rising edge
  reset  in  1  reset, synchronous, active-high
  pc_reset  in  1  PC clear request from pipeline control
  pc_inc  in  1  PC increment enable
  pc_load  in  1  PC load enable
  pc_load_sel  in  2  load source: 00 branch_addr, 01 ret_addr, 10 interrupt vector 0x3FF, 11 branch_addr
  branch_addr  in  10  branch/call target
  ret_addr  in  10  return address from stack
  imem_addr_mux  in  1  1 = replay previous imem address
  fetch_latch_stall  in  1  hold fetch latch
  dec_nop  in  1  squash word being captured
  imem_addr  out  10  instruction memory address, combinational
  imem_data  in  18  synchronous-read data for the address issued the previous cycle
  if_instr  out  18  latched instruction to decode
  if_pc  out  10  address of if_instr
  if_valid  out  1  if_instr is a real instruction
REQ-002 SHALL have parameters: PC_W, default 10, PC width; INSTR_W, default 18, instruction width; INT_VEC, default 10'h3FF, interrupt vector.

Function
REQ-003 SHALL hold PC register pc; next-PC priority: reset or pc_reset -> 0; else pc_load -> source per pc_load_sel; else pc_inc -> pc+1; else hold.
REQ-004 SHALL wrap pc+1 modulo 2^PC_W (0x3FF -> 0x000), no flag.
REQ-005 SHALL drive imem_addr = addr_q when imem_addr_mux=1, else pc.
REQ-006 SHALL register addr_q <= imem_addr every cycle; reset value 0.
REQ-007 SHALL register req_v: 0 on reset or pc_reset, else 1; req_v=1 marks imem_data valid this cycle.
REQ-008 SHALL, when fetch_latch_stall=0, capture if_instr <= imem_data, if_pc <= addr_q, if_valid <= req_v & ~dec_nop.
REQ-009 SHALL, when fetch_latch_stall=1, hold if_instr, if_pc and if_valid unchanged regardless of dec_nop.
REQ-010 SHALL, on simultaneous pc_load and fetch_latch_stall, load pc and hold the latch in the same cycle.
REQ-011 SHALL ignore pc_inc whenever pc_load=1 and ignore both whenever pc_reset=1.
REQ-012 SHALL have a fetch-to-latch latency of exactly one cycle: address presented in cycle N appears on if_instr/if_pc after edge N+1.
REQ-013 SHALL, on pc_reset without reset, clear pc and req_v only; latch captures normally, so if_valid=0 the next cycle.

Reset
REQ-014 SHALL, on reset=1 at a clock edge, set pc=0, addr_q=0, req_v=0, if_instr=0, if_pc=0, if_valid=0; reset mid-stall overrides the stall.
REQ-015 SHALL output imem_addr=0 in the first cycle after reset is released.

Configuration
REQ-016 SHALL compile fetch performance counters only when FETCH_PERF_CNT_EN is defined: outputs stall_cnt (16) and flush_cnt (16).
REQ-017 SHALL, with FETCH_PERF_CNT_EN, increment stall_cnt each cycle fetch_latch_stall=1 and flush_cnt each cycle fetch_latch_stall=0 & dec_nop=1 & req_v=1; both saturate at 0xFFFF and clear on reset.
REQ-018 SHALL, without FETCH_PERF_CNT_EN, omit the counter ports and logic; all other behaviour identical.

Verification
REQ-019 Reset, then pc_inc=1 for 4 cycles with imem returning addr-tagged data -> imem_addr 0,1,2,3; if_pc 0,1,2 with if_valid=1 from the second capture.
REQ-020 pc=0x3FF, pc_inc=1 -> pc=0x000, imem_addr=0x000 next cycle.
REQ-021 pc=0x010, pc_load=1, sel=10 while dec_nop=1 -> pc=0x3FF; captured if_valid=0; next capture if_pc=0x010.
REQ-022 fetch_latch_stall=1 and imem_addr_mux=1 for 2 cycles at addr_q=0x020 -> imem_addr=0x020 both cycles; if_instr/if_pc frozen; release -> if_pc=0x020.
REQ-023 pc_load=1 (sel=01, ret_addr=0x055) with fetch_latch_stall=1 -> pc=0x055, latch held.
REQ-024 FETCH_PERF_CNT_EN defined, stall 3 cycles then dec_nop 2 cycles -> stall_cnt=3, flush_cnt=2; preload stall_cnt=0xFFFF, stall -> stays 0xFFFF.
